// File: rtl/vga_pixel_unpack.sv
// ----------------------------------------------------------------------------
// vga_pixel_unpack
//
// Unpacks words from an upstream first-word-fall-through FIFO into a stream
// of pixels for the display timing logic. Each FIFO word carries
// PPW = DATA_SIZE/PIXEL_SIZE pixels, least-significant pixel first. A pixel
// request in cycle N produces the registered pixel in cycle N+1. When the
// FIFO cannot supply data, black is substituted and an underflow event is
// recorded. A frame-start pulse realigns the word phase so every frame begins
// on a word boundary, discarding any partially consumed word.
//
// Parameters
//   DATA_SIZE          width of one FIFO word (default 32)
//   PIXEL_SIZE         width of one pixel (default 16); DATA_SIZE/PIXEL_SIZE
//                      must be a power of two in 1..8
//
// Ports
//   CLK                sole clock, all state updates on the rising edge
//   RST                asynchronous active-high reset
//   FIFO_DATA_IN       head word of the upstream FWFT FIFO
//   FIFO_EMPTY_IN      1 = FIFO has no valid head word
//   FIFO_RD_OUT        combinational pop strobe for the head word
//   FRAME_START_IN     single-cycle pulse during vertical blanking
//   PIXEL_REQ_IN       display consumes one pixel this cycle
//   PIXEL_OUT          registered pixel value
//   PIXEL_VALID_OUT    registered; 1 = pixel from FIFO, 0 = black substitute
//   UNDERFLOW_OUT      sticky underflow flag
//   UNDERFLOW_CNT_OUT  saturating underflow event counter
//   UNDERFLOW_CLR_IN   clears the underflow flag and counter
// ----------------------------------------------------------------------------
module vga_pixel_unpack #(
    parameter int DATA_SIZE  = 32,
    parameter int PIXEL_SIZE = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_SIZE-1:0]  FIFO_DATA_IN,
    input  logic                  FIFO_EMPTY_IN,
    output logic                  FIFO_RD_OUT,
    input  logic                  FRAME_START_IN,
    input  logic                  PIXEL_REQ_IN,
    output logic [PIXEL_SIZE-1:0] PIXEL_OUT,
    output logic                  PIXEL_VALID_OUT,
    output logic                  UNDERFLOW_OUT,
    output logic [15:0]           UNDERFLOW_CNT_OUT,
    input  logic                  UNDERFLOW_CLR_IN
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int PPW   = DATA_SIZE / PIXEL_SIZE;
    // A single-pixel word needs no index; keep a 1-bit register that is held
    // at zero so the rest of the logic does not need zero-width special cases.
    localparam int PTR_W = (PPW > 1) ? $clog2(PPW) : 1;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    state_t                state_reg;
    state_t                state_next;
    logic [PTR_W-1:0]      ptr_reg;
    logic [PTR_W-1:0]      ptr_next;

    logic [PIXEL_SIZE-1:0] pixel_reg;
    logic [PIXEL_SIZE-1:0] pixel_next;
    logic                  valid_reg;
    logic                  valid_next;

    logic                  uflag_reg;
    logic                  uflag_next;
    logic [15:0]           ucnt_reg;
    logic [15:0]           ucnt_next;

    logic                  fifo_rd;
    logic                  uf_event;

    logic [PIXEL_SIZE-1:0] lane [PPW];
    logic [PIXEL_SIZE-1:0] lane_sel;
    logic                  ptr_last;
    logic                  ptr_zero;

    // A request is only serviced as a pixel when no frame start competes
    // with it in the same cycle; frame-start handling always takes priority.
    logic                  req_eff;
    assign req_eff = PIXEL_REQ_IN & ~FRAME_START_IN;

    // ------------------------------------------------------------------------
    // Word -> pixel lanes. Lane k holds bits [k*PIXEL_SIZE +: PIXEL_SIZE];
    // lane 0 is displayed first.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < PPW; gi++) begin : g_lane
            assign lane[gi] = FIFO_DATA_IN[gi*PIXEL_SIZE +: PIXEL_SIZE];
        end

        if (PPW == 1) begin : g_ptr_single
            // Every pixel is the last pixel of its word.
            assign lane_sel = lane[0];
            assign ptr_last = 1'b1;
            assign ptr_zero = 1'b1;
        end else begin : g_ptr_multi
            assign lane_sel = lane[ptr_reg];
            assign ptr_last = (ptr_reg == PTR_W'(PPW - 1));
            assign ptr_zero = (ptr_reg == '0);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM process 1: state and pixel-index registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state and next-index logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (FRAME_START_IN) begin
                    state_next = ST_ACTIVE;
                    ptr_next   = '0;
                end
            end

            ST_ACTIVE: begin
                if (FRAME_START_IN) begin
                    // Realign to a word boundary. A partially consumed word
                    // that cannot be dropped yet (FIFO empty) is dropped as
                    // soon as it shows up, from FLUSH.
                    ptr_next = '0;
                    if (!ptr_zero && FIFO_EMPTY_IN) begin
                        state_next = ST_FLUSH;
                    end
                end else if (req_eff && !FIFO_EMPTY_IN) begin
                    ptr_next = ptr_last ? '0 : ptr_reg + PTR_W'(1);
                end
            end

            ST_FLUSH: begin
                // Frame start here is ignored: the discard is already pending.
                if (!FIFO_EMPTY_IN) begin
                    state_next = ST_ACTIVE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: outputs -- FIFO pop, next pixel, underflow event
    // ------------------------------------------------------------------------
    always_comb begin
        fifo_rd    = 1'b0;
        pixel_next = '0;
        valid_next = 1'b0;
        uf_event   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Requests before the first frame start are silently black.
            end

            ST_ACTIVE: begin
                if (FRAME_START_IN) begin
                    // Drop the rest of a partially consumed word.
                    fifo_rd = ~ptr_zero & ~FIFO_EMPTY_IN;
                end else if (req_eff) begin
                    if (!FIFO_EMPTY_IN) begin
                        pixel_next = lane_sel;
                        valid_next = 1'b1;
                        fifo_rd    = ptr_last;
                    end else begin
                        uf_event = 1'b1;
                    end
                end
            end

            ST_FLUSH: begin
                fifo_rd  = ~FIFO_EMPTY_IN;
                uf_event = req_eff;
            end

            default: begin
            end
        endcase
    end

    assign FIFO_RD_OUT = fifo_rd;

    // ------------------------------------------------------------------------
    // Registered pixel output
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pixel_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            pixel_reg <= pixel_next;
            valid_reg <= valid_next;
        end
    end

    assign PIXEL_OUT       = pixel_reg;
    assign PIXEL_VALID_OUT = valid_reg;

    // ------------------------------------------------------------------------
    // Underflow flag and saturating counter. A clear coinciding with an event
    // restarts the statistics at that event rather than losing it.
    // ------------------------------------------------------------------------
    always_comb begin
        uflag_next = uflag_reg;
        ucnt_next  = ucnt_reg;
        if (UNDERFLOW_CLR_IN) begin
            uflag_next = uf_event;
            ucnt_next  = {15'd0, uf_event};
        end else if (uf_event) begin
            uflag_next = 1'b1;
            if (ucnt_reg != CNT_MAX) begin
                ucnt_next = ucnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            uflag_reg <= 1'b0;
            ucnt_reg  <= '0;
        end else begin
            uflag_reg <= uflag_next;
            ucnt_reg  <= ucnt_next;
        end
    end

    assign UNDERFLOW_OUT     = uflag_reg;
    assign UNDERFLOW_CNT_OUT = ucnt_reg;

endmodule

// File: tb/tb_vga_pixel_unpack.sv
// ----------------------------------------------------------------------------
// tb_vga_pixel_unpack
//
// Bench for vga_pixel_unpack with default parameters (32-bit words, 16-bit
// pixels, two pixels per word). The bench owns a queue that plays the role of
// the upstream FWFT FIFO and keeps a behavioural model of the display-side
// contract: a mode (idle / active / flush), the number of pixels already
// taken from the head word, and the underflow statistics. Each cycle compares
// the DUT pop strobe and the registered outputs against that model.
// ----------------------------------------------------------------------------
module tb_vga_pixel_unpack;

    localparam int PIX = 16;
    localparam int PPW = 2;

    logic        CLK;
    logic        RST;
    logic [31:0] FIFO_DATA_IN;
    logic        FIFO_EMPTY_IN;
    logic        FIFO_RD_OUT;
    logic        FRAME_START_IN;
    logic        PIXEL_REQ_IN;
    logic [15:0] PIXEL_OUT;
    logic        PIXEL_VALID_OUT;
    logic        UNDERFLOW_OUT;
    logic [15:0] UNDERFLOW_CNT_OUT;
    logic        UNDERFLOW_CLR_IN;

    vga_pixel_unpack #(
        .DATA_SIZE  (32),
        .PIXEL_SIZE (16)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .FIFO_DATA_IN      (FIFO_DATA_IN),
        .FIFO_EMPTY_IN     (FIFO_EMPTY_IN),
        .FIFO_RD_OUT       (FIFO_RD_OUT),
        .FRAME_START_IN    (FRAME_START_IN),
        .PIXEL_REQ_IN      (PIXEL_REQ_IN),
        .PIXEL_OUT         (PIXEL_OUT),
        .PIXEL_VALID_OUT   (PIXEL_VALID_OUT),
        .UNDERFLOW_OUT     (UNDERFLOW_OUT),
        .UNDERFLOW_CNT_OUT (UNDERFLOW_CNT_OUT),
        .UNDERFLOW_CLR_IN  (UNDERFLOW_CLR_IN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic        rd;
        logic        valid;
        logic [15:0] pix;
        logic        flag;
        logic [15:0] cnt;
    } obs_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          verbose  = 1'b1;
    int          cyc      = 0;

    logic [31:0] fifo_q [$];

    // Behavioural model: 0 = waiting for frame start, 1 = streaming,
    // 2 = waiting to discard a half-used word.
    int          m_mode;
    int          m_used;
    bit          m_flag;
    int          m_cnt;

    task automatic drive_fifo();
        FIFO_EMPTY_IN = (fifo_q.size() == 0);
        FIFO_DATA_IN  = FIFO_EMPTY_IN ? $urandom() : fifo_q[0];
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    task automatic flush_queue();
        fifo_q.delete();
        drive_fifo();
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_used = 0;
        m_flag = 1'b0;
        m_cnt  = 0;
    endtask

    // Expected behaviour for one cycle, from the rules of the block.
    task automatic model_step(input bit fs, input bit req, input bit clr,
                              output obs_t e);
        bit          empty;
        logic [31:0] head;
        bit          ev;
        empty = (fifo_q.size() == 0);
        head  = empty ? 32'd0 : fifo_q[0];
        ev    = 1'b0;
        e     = '0;
        if (m_mode == 0) begin
            if (fs) begin
                m_mode = 1;
                m_used = 0;
            end
        end else if (m_mode == 1) begin
            if (fs) begin
                if (m_used != 0) begin
                    if (!empty) e.rd = 1'b1;
                    else        m_mode = 2;
                end
                m_used = 0;
            end else if (req) begin
                if (!empty) begin
                    e.pix   = 16'((head >> (PIX * m_used)) & 32'hFFFF);
                    e.valid = 1'b1;
                    m_used  = m_used + 1;
                    if (m_used == PPW) begin
                        e.rd   = 1'b1;
                        m_used = 0;
                    end
                end else begin
                    ev = 1'b1;
                end
            end
        end else begin
            if (req && !fs) ev = 1'b1;
            if (!empty) begin
                e.rd   = 1'b1;
                m_mode = 1;
            end
        end
        if (clr) begin
            m_flag = ev;
            m_cnt  = ev ? 1 : 0;
        end else if (ev) begin
            m_flag = 1'b1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        e.flag = m_flag;
        e.cnt  = 16'(m_cnt);
    endtask

    // Drives one clock cycle (starting 1 time unit after a rising edge) and
    // returns the observed and expected results for it.
    task automatic cycle(input bit fs, input bit req, input bit clr,
                         output obs_t o, output obs_t e);
        logic rd_now;
        FRAME_START_IN   = fs;
        PIXEL_REQ_IN     = req;
        UNDERFLOW_CLR_IN = clr;
        #2;
        rd_now = FIFO_RD_OUT;
        model_step(fs, req, clr, e);
        @(posedge CLK);
        #1;
        if (rd_now === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
        o.rd    = rd_now;
        o.valid = PIXEL_VALID_OUT;
        o.pix   = PIXEL_OUT;
        o.flag  = UNDERFLOW_OUT;
        o.cnt   = UNDERFLOW_CNT_OUT;
        FRAME_START_IN   = 1'b0;
        PIXEL_REQ_IN     = 1'b0;
        UNDERFLOW_CLR_IN = 1'b0;
        drive_fifo();
        cyc++;
        if (verbose)
            $display("cyc %0d fs=%b req=%b clr=%b -> rd=%b valid=%b pix=%h uf=%b cnt=%0d",
                     cyc, fs, req, clr, o.rd, o.valid, o.pix, o.flag, o.cnt);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        obs_t o, e;
        RST = 1'b1;
        flush_queue();
        push(32'h1234_5678);
        FRAME_START_IN = 1'b1;
        PIXEL_REQ_IN   = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (FIFO_RD_OUT !== 1'b0)
            $display("FAIL reset_rd got=%b want=0", FIFO_RD_OUT);
        else n_pass++;
        n_checks++;
        if ({PIXEL_VALID_OUT, PIXEL_OUT} !== 17'd0)
            $display("FAIL reset_pixel got valid=%b pix=%h want 0/0", PIXEL_VALID_OUT, PIXEL_OUT);
        else n_pass++;
        n_checks++;
        if ({UNDERFLOW_OUT, UNDERFLOW_CNT_OUT} !== 17'd0)
            $display("FAIL reset_underflow got flag=%b cnt=%0d want 0/0", UNDERFLOW_OUT, UNDERFLOW_CNT_OUT);
        else n_pass++;
        FRAME_START_IN = 1'b0;
        PIXEL_REQ_IN   = 1'b0;
        RST = 1'b0;
        model_reset();
        // Idle requests: black, no pop, no underflow.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, o, e);
            n_checks++;
            if (o !== e || o !== obs_t'(0))
                $display("FAIL idle_req%0d got=%h want=%h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        obs_t o, e;
        flush_queue();
        push(32'hBBBB_AAAA);
        cycle(1'b1, 1'b0, 1'b0, o, e);
        n_checks++;
        if (o !== e) $display("FAIL basic_fs got=%h want=%h", o, e);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0, o, e);
        n_checks++;
        if (o.pix !== 16'hAAAA || o.valid !== 1'b1 || o.rd !== 1'b0)
            $display("FAIL basic_px0 got pix=%h valid=%b rd=%b want AAAA/1/0", o.pix, o.valid, o.rd);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0, o, e);
        n_checks++;
        if (o.pix !== 16'hBBBB || o.valid !== 1'b1 || o.rd !== 1'b1)
            $display("FAIL basic_px1 got pix=%h valid=%b rd=%b want BBBB/1/1", o.pix, o.valid, o.rd);
        else n_pass++;
        n_checks++;
        if (o !== e) $display("FAIL basic_model got=%h want=%h", o, e);
        else n_pass++;
    endtask

    task automatic test_underflow();
        obs_t o, e;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, o, e);
            n_checks++;
            if (o !== e) $display("FAIL uf_req%0d got=%h want=%h", i, o, e);
            else n_pass++;
        end
        n_checks++;
        if (o.flag !== 1'b1 || o.cnt !== 16'd3 || o.valid !== 1'b0 || o.pix !== 16'd0)
            $display("FAIL uf_count got flag=%b cnt=%0d valid=%b pix=%h want 1/3/0/0",
                     o.flag, o.cnt, o.valid, o.pix);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, o, e);
        n_checks++;
        if (o.flag !== 1'b0 || o.cnt !== 16'd0)
            $display("FAIL uf_clear got flag=%b cnt=%0d want 0/0", o.flag, o.cnt);
        else n_pass++;
        // Index was left untouched by the underflows: pixel 0 comes next.
        push(32'h2222_1111);
        cycle(1'b0, 1'b1, 1'b0, o, e);
        n_checks++;
        if (o.pix !== 16'h1111 || o.valid !== 1'b1 || o !== e)
            $display("FAIL uf_resume got=%h want=%h", o, e);
        else n_pass++;
    endtask

    task automatic test_realign();
        obs_t o, e;
        // One pixel of 2222_1111 already consumed.
        push(32'h4444_3333);
        cycle(1'b1, 1'b0, 1'b0, o, e);
        n_checks++;
        if (o.rd !== 1'b1 || o !== e)
            $display("FAIL realign_pop got=%h want=%h", o, e);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0, o, e);
        n_checks++;
        if (o.pix !== 16'h3333 || o.valid !== 1'b1 || o.rd !== 1'b0)
            $display("FAIL realign_px got pix=%h valid=%b rd=%b want 3333/1/0", o.pix, o.valid, o.rd);
        else n_pass++;
    endtask

    task automatic test_flush();
        obs_t o, e;
        // Index is 1 on the head word; make the FIFO appear empty.
        flush_queue();
        cycle(1'b1, 1'b0, 1'b1, o, e);
        n_checks++;
        if (o.rd !== 1'b0 || o.cnt !== 16'd0 || o !== e)
            $display("FAIL flush_enter got=%h want=%h", o, e);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0, o, e);
        cycle(1'b0, 1'b1, 1'b0, o, e);
        n_checks++;
        if (o.cnt !== 16'd2 || o.flag !== 1'b1 || o.valid !== 1'b0 || o.pix !== 16'd0)
            $display("FAIL flush_uf got cnt=%0d flag=%b valid=%b pix=%h want 2/1/0/0",
                     o.cnt, o.flag, o.valid, o.pix);
        else n_pass++;
        push(32'h6666_5555);
        push(32'h8888_7777);
        cycle(1'b0, 1'b0, 1'b0, o, e);
        n_checks++;
        if (o.rd !== 1'b1 || o !== e)
            $display("FAIL flush_pop got=%h want=%h", o, e);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0, o, e);
        n_checks++;
        if (o.pix !== 16'h7777 || o.valid !== 1'b1 || o.rd !== 1'b0 || o !== e)
            $display("FAIL flush_resume got=%h want=%h", o, e);
        else n_pass++;
    endtask

    task automatic test_random();
        obs_t o, e;
        int   bad;
        bad = 0;
        do_reset();
        flush_queue();
        for (int i = 0; i < 1500; i++) begin
            bit fs, req, clr;
            if ($urandom_range(2, 0) == 0 && fifo_q.size() < 6) push($urandom());
            fs  = ($urandom_range(39, 0) == 0);
            req = ($urandom_range(3, 0) != 0);
            clr = ($urandom_range(49, 0) == 0);
            cycle(fs, req, clr, o, e);
            n_checks++;
            if (o !== e) begin
                if (bad < 20)
                    $display("FAIL random_cyc%0d got=%h want=%h (rd,valid,pix,flag,cnt)", i, o, e);
                bad++;
            end else n_pass++;
        end
    endtask

    task automatic test_saturate();
        obs_t o, e;
        int   bad;
        bad = 0;
        do_reset();
        flush_queue();
        cycle(1'b1, 1'b0, 1'b0, o, e);
        verbose = 1'b0;
        for (int i = 0; i < 65538; i++) begin
            cycle(1'b0, 1'b1, 1'b0, o, e);
            if (o !== e) bad++;
        end
        verbose = 1'b1;
        n_checks++;
        if (bad != 0) $display("FAIL sat_sequence got %0d mismatching cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (o.cnt !== 16'hFFFF || o.flag !== 1'b1)
            $display("FAIL sat_hold got cnt=%h flag=%b want FFFF/1", o.cnt, o.flag);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b1, o, e);
        n_checks++;
        if (o.cnt !== 16'd1 || o.flag !== 1'b1)
            $display("FAIL sat_clr_event got cnt=%0d flag=%b want 1/1", o.cnt, o.flag);
        else n_pass++;
    endtask

    task automatic test_reset_midword();
        obs_t o, e;
        do_reset();
        flush_queue();
        push(32'hD00D_C00C);
        cycle(1'b1, 1'b0, 1'b0, o, e);
        cycle(1'b0, 1'b1, 1'b0, o, e);
        n_checks++;
        if (o.pix !== 16'hC00C || o.valid !== 1'b1)
            $display("FAIL mid_px0 got pix=%h valid=%b want C00C/1", o.pix, o.valid);
        else n_pass++;
        // Asynchronous reset in the middle of a cycle.
        RST = 1'b1;
        #1;
        n_checks++;
        if ({FIFO_RD_OUT, PIXEL_VALID_OUT, PIXEL_OUT, UNDERFLOW_OUT, UNDERFLOW_CNT_OUT} !== 35'd0)
            $display("FAIL mid_async got rd=%b valid=%b pix=%h flag=%b cnt=%0d want all 0",
                     FIFO_RD_OUT, PIXEL_VALID_OUT, PIXEL_OUT, UNDERFLOW_OUT, UNDERFLOW_CNT_OUT);
        else n_pass++;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, o, e);
            n_checks++;
            if (o !== obs_t'(0) || o !== e)
                $display("FAIL mid_idle%0d got=%h want=%h", i, o, e);
            else n_pass++;
        end
        // Frame start together with a request: request is dropped.
        cycle(1'b1, 1'b1, 1'b0, o, e);
        n_checks++;
        if (o !== e || o.valid !== 1'b0 || o.cnt !== 16'd0)
            $display("FAIL mid_fs_req got=%h want=%h", o, e);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0, o, e);
        n_checks++;
        if (o.pix !== 16'hC00C || o.valid !== 1'b1 || o !== e)
            $display("FAIL mid_restart got=%h want=%h", o, e);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        RST              = 1'b1;
        FRAME_START_IN   = 1'b0;
        PIXEL_REQ_IN     = 1'b0;
        UNDERFLOW_CLR_IN = 1'b0;
        model_reset();
        drive_fifo();
        @(posedge CLK);
        #1;
        test_reset();
        test_basic();
        test_underflow();
        test_realign();
        test_flush();
        test_random();
        test_saturate();
        test_reset_midword();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
